// File: rtl/ncu_mcu_link_mon.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ncu_mcu_link_mon : NCU<->MCU vld/data/stall link framing & error monitor |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module ncu_mcu_link_mon #(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 4,
  parameter int PKT_BEATS = 32,
  parameter int CNT_W     = 16,
  localparam int c_CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     iol2clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr_cnt,
  input  logic [N_CH-1:0]          vld,
  input  logic [N_CH*DATA_W-1:0]   data,
  input  logic [N_CH-1:0]          stall,
  output logic [N_CH-1:0]          pkt_done,
  output logic [N_CH*CNT_W-1:0]    pkt_cnt,
  output logic [N_CH*DATA_W-1:0]   hdr,
  output logic [N_CH-1:0]          err_trunc,
  output logic [N_CH-1:0]          err_stall_start,
  output logic                     first_err_vld,
  output logic [c_CH_W-1:0]        first_err_ch,
  output logic [1:0]               first_err_code
);

  localparam int                  c_BEAT_W = $clog2(PKT_BEATS);
  localparam logic [c_BEAT_W-1:0] c_LAST   = c_BEAT_W'(PKT_BEATS - 1);
  localparam logic [CNT_W-1:0]    c_CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t              r_state [N_CH];
  logic [c_BEAT_W-1:0] r_beat  [N_CH];
  logic [DATA_W-1:0]   r_pend  [N_CH];

  logic [N_CH-1:0]     w_trunc;
  logic [N_CH-1:0]     w_sstart;
  logic                w_fe_hit;
  logic [c_CH_W-1:0]   w_fe_ch;
  logic [1:0]          w_fe_code;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_trunc[i]  = en && (r_state[i] == S_XFER) && !vld[i];
      w_sstart[i] = en && (r_state[i] == S_IDLE) && vld[i] && stall[i];
    end
  end

  // Descending scan so the lowest erroring channel is the one left standing.
  always_comb begin
    w_fe_hit  = 1'b0;
    w_fe_ch   = '0;
    w_fe_code = 2'b00;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_trunc[i] || w_sstart[i]) begin
        w_fe_hit  = 1'b1;
        w_fe_ch   = c_CH_W'(i);
        w_fe_code = w_trunc[i] ? 2'b01 : 2'b10;
      end
    end
  end

  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_state[i] <= S_IDLE;
        r_beat[i]  <= '0;
        r_pend[i]  <= '0;
      end
      pkt_done        <= '0;
      pkt_cnt         <= '0;
      hdr             <= '0;
      err_trunc       <= '0;
      err_stall_start <= '0;
      first_err_vld   <= 1'b0;
      first_err_ch    <= '0;
      first_err_code  <= 2'b00;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        pkt_done[i] <= 1'b0;
        if (!en) begin
          r_state[i] <= S_IDLE;
          r_beat[i]  <= '0;
        end else if (r_state[i] == S_IDLE) begin
          if (vld[i]) begin
            r_pend[i]  <= data[i*DATA_W +: DATA_W];
            r_beat[i]  <= c_BEAT_W'(1);
            r_state[i] <= S_XFER;
          end
        end else if (!vld[i]) begin
          r_state[i] <= S_IDLE;
          r_beat[i]  <= '0;
        end else if (r_beat[i] == c_LAST) begin
          r_state[i]              <= S_IDLE;
          r_beat[i]               <= '0;
          pkt_done[i]             <= 1'b1;
          hdr[i*DATA_W +: DATA_W] <= r_pend[i];
          if (pkt_cnt[i*CNT_W +: CNT_W] != c_CNT_MAX)
            pkt_cnt[i*CNT_W +: CNT_W] <= pkt_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
        end else begin
          r_beat[i] <= r_beat[i] + c_BEAT_W'(1);
        end
        // Clear overrides any same-cycle increment above.
        if (clr_cnt)
          pkt_cnt[i*CNT_W +: CNT_W] <= '0;
      end

      if (clr_cnt) begin
        err_trunc       <= '0;
        err_stall_start <= '0;
        first_err_vld   <= 1'b0;
        first_err_ch    <= '0;
        first_err_code  <= 2'b00;
      end else begin
        err_trunc       <= err_trunc | w_trunc;
        err_stall_start <= err_stall_start | w_sstart;
        if (!first_err_vld && w_fe_hit) begin
          first_err_vld  <= 1'b1;
          first_err_ch   <= w_fe_ch;
          first_err_code <= w_fe_code;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ncu_mcu_link_mon.sv
`default_nettype none
// Bench for ncu_mcu_link_mon: directed link traffic against a per-packet model.
// CNT_W is narrowed to 4 so counter saturation is reachable in a short run.
module tb_ncu_mcu_link_mon;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int PB = 32;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            clr = 1'b0;
  logic [N-1:0]    vld = '0;
  logic [N-1:0]    stall = '0;
  logic [N*DW-1:0] data = '0;

  logic [N-1:0]    pkt_done;
  logic [N*CW-1:0] pkt_cnt;
  logic [N*DW-1:0] hdr;
  logic [N-1:0]    err_trunc;
  logic [N-1:0]    err_stall_start;
  logic            first_err_vld;
  logic [1:0]      first_err_ch;
  logic [1:0]      first_err_code;

  ncu_mcu_link_mon #(.N_CH(N), .DATA_W(DW), .PKT_BEATS(PB), .CNT_W(CW)) dut (
    .iol2clk(clk), .rst(rst), .en(en), .clr_cnt(clr),
    .vld(vld), .data(data), .stall(stall),
    .pkt_done(pkt_done), .pkt_cnt(pkt_cnt), .hdr(hdr),
    .err_trunc(err_trunc), .err_stall_start(err_stall_start),
    .first_err_vld(first_err_vld), .first_err_ch(first_err_ch),
    .first_err_code(first_err_code)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per channel, how many beats of the current packet have been seen.
  int            m_seen [N];
  logic [DW-1:0] m_pend [N];
  logic [DW-1:0] m_hdr  [N];
  int            m_cnt  [N];
  logic [N-1:0]  m_done, m_et, m_es;
  logic          m_fev;
  int            m_fech;
  logic [1:0]    m_fec;

  always @(posedge clk or posedge rst) begin : model
    logic [N-1:0] nt, ns;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_seen[i] = 0; m_pend[i] = '0; m_hdr[i] = '0; m_cnt[i] = 0;
      end
      m_done = '0; m_et = '0; m_es = '0; m_fev = 1'b0; m_fech = 0; m_fec = 2'b00;
    end else begin
      nt = '0;
      ns = '0;
      for (int i = 0; i < N; i++) begin
        m_done[i] = 1'b0;
        if (!en) begin
          m_seen[i] = 0;
        end else if (m_seen[i] == 0) begin
          if (vld[i]) begin
            m_pend[i] = data[i*DW +: DW];
            m_seen[i] = 1;
            if (stall[i]) ns[i] = 1'b1;
          end
        end else if (!vld[i]) begin
          nt[i] = 1'b1;
          m_seen[i] = 0;
        end else begin
          m_seen[i] = m_seen[i] + 1;
          if (m_seen[i] == PB) begin
            m_done[i] = 1'b1;
            m_hdr[i]  = m_pend[i];
            if (m_cnt[i] < (1 << CW) - 1) m_cnt[i] = m_cnt[i] + 1;
            m_seen[i] = 0;
          end
        end
      end
      if (clr) begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_et = '0; m_es = '0; m_fev = 1'b0; m_fech = 0; m_fec = 2'b00;
      end else begin
        m_et = m_et | nt;
        m_es = m_es | ns;
        if (!m_fev && (nt | ns) != '0) begin
          m_fev = 1'b1;
          for (int i = N - 1; i >= 0; i--)
            if (nt[i] || ns[i]) begin
              m_fech = i;
              m_fec  = nt[i] ? 2'b01 : 2'b10;
            end
        end
      end
    end
  end

  logic [N*CW-1:0] e_cnt;
  logic [N*DW-1:0] e_hdr;

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      for (int i = 0; i < N; i++) begin
        e_cnt[i*CW +: CW] = CW'(m_cnt[i]);
        e_hdr[i*DW +: DW] = m_hdr[i];
      end
      chk("m_pkt_done", 64'(pkt_done), 64'(m_done));
      chk("m_pkt_cnt", 64'(pkt_cnt), 64'(e_cnt));
      chk("m_hdr", 64'(hdr), 64'(e_hdr));
      chk("m_err_trunc", 64'(err_trunc), 64'(m_et));
      chk("m_err_stall", 64'(err_stall_start), 64'(m_es));
      chk("m_fe_vld", 64'(first_err_vld), 64'(m_fev));
      chk("m_fe_ch", 64'(first_err_ch), 64'(m_fech[1:0]));
      chk("m_fe_code", 64'(first_err_code), 64'(m_fec));
    end
  end

  // Drives nb beats on channel ch (beat 0 carries h0); vld is left high.
  task automatic pkt(input int ch, input int nb, input logic [DW-1:0] h0);
    for (int b = 0; b < nb; b++) begin
      vld[ch] = 1'b1;
      data[ch*DW +: DW] = (b == 0) ? h0 : DW'(b);
      @(negedge clk);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_done"}, 64'(pkt_done), 64'h0);
    chk({nm, "_cnt"}, 64'(pkt_cnt), 64'h0);
    chk({nm, "_hdr"}, 64'(hdr), 64'h0);
    chk({nm, "_err"}, 64'({err_trunc, err_stall_start}), 64'h0);
    chk({nm, "_fe"}, 64'({first_err_vld, first_err_ch, first_err_code}), 64'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    chk_on = 1'b1;
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);

    // Single clean packet on ch0
    pkt(0, PB, 4'h0);
    vld = '0;
    chk("ch0_done", 64'(pkt_done), 64'h1);
    chk("ch0_cnt", 64'(pkt_cnt[0 +: CW]), 64'h1);
    chk("ch0_hdr", 64'(hdr[0 +: DW]), 64'h0);
    chk("ch0_noerr", 64'({err_trunc, err_stall_start}), 64'h0);
    @(negedge clk);
    chk("ch0_pulse_end", 64'(pkt_done), 64'h0);

    // Back-to-back packets on ch2
    pkt(2, PB, 4'hA);
    chk("ch2_first_done", 64'(pkt_done), 64'h4);
    pkt(2, PB, 4'h5);
    vld = '0;
    chk("ch2_cnt", 64'(pkt_cnt[2*CW +: CW]), 64'h2);
    chk("ch2_hdr", 64'(hdr[2*DW +: DW]), 64'h5);

    // Truncation on ch1 after beat 10, then a full packet
    pkt(1, 11, 4'h3);
    vld[1] = 1'b0;
    @(negedge clk);
    chk("ch1_trunc", 64'(err_trunc), 64'h2);
    chk("ch1_fe", 64'({first_err_vld, first_err_ch, first_err_code}), 64'b1_01_01);
    chk("ch1_cnt0", 64'(pkt_cnt[CW +: CW]), 64'h0);
    pkt(1, PB, 4'h7);
    vld = '0;
    chk("ch1_cnt1", 64'(pkt_cnt[CW +: CW]), 64'h1);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_cnt", 64'(pkt_cnt), 64'h0);
    chk("clr_err", 64'({err_trunc, err_stall_start, first_err_vld}), 64'h0);

    // ch3 starts against stall in the same cycle ch1 truncates
    pkt(1, 5, 4'h1);
    vld[1] = 1'b0;
    vld[3] = 1'b1;
    stall[3] = 1'b1;
    data[3*DW +: DW] = 4'hC;
    @(negedge clk);
    stall[3] = 1'b0;
    for (int b = 1; b < PB; b++) begin
      data[3*DW +: DW] = DW'(b);
      @(negedge clk);
    end
    vld = '0;
    chk("dual_trunc", 64'(err_trunc), 64'h2);
    chk("dual_stall", 64'(err_stall_start), 64'h8);
    chk("dual_fe", 64'({first_err_vld, first_err_ch, first_err_code}), 64'b1_01_01);
    chk("ch3_cnt", 64'(pkt_cnt[3*CW +: CW]), 64'h1);
    chk("ch3_hdr", 64'(hdr[3*DW +: DW]), 64'hC);

    // Saturation: 14 packets (all-ones minus one), then two more
    for (int k = 0; k < 14; k++) pkt(0, PB, DW'(k));
    chk("sat_pre", 64'(pkt_cnt[0 +: CW]), 64'hE);
    pkt(0, PB, 4'h1);
    pkt(0, PB, 4'h2);
    chk("sat_cnt", 64'(pkt_cnt[0 +: CW]), 64'hF);
    chk("sat_done", 64'(pkt_done[0]), 64'h1);

    // Clear coincident with a completion
    pkt(0, PB - 1, 4'h4);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    vld = '0;
    chk("clr_done", 64'(pkt_done[0]), 64'h1);
    chk("clr_cnt0", 64'(pkt_cnt[0 +: CW]), 64'h0);
    chk("clr_hdr0", 64'(hdr[0 +: DW]), 64'h4);

    // Enable dropped at beat 5, re-entry with vld high is a fresh beat 0
    pkt(2, 5, 4'h9);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    pkt(2, PB, 4'h6);
    vld = '0;
    chk("en_noerr", 64'({err_trunc, err_stall_start, first_err_vld}), 64'h0);
    chk("en_cnt2", 64'(pkt_cnt[2*CW +: CW]), 64'h1);
    chk("en_hdr2", 64'(hdr[2*DW +: DW]), 64'h6);

    // Asynchronous reset mid-packet
    pkt(0, 10, 4'h2);
    vld = '0;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    pkt(0, PB, 4'hE);
    vld = '0;
    chk("post_rst_cnt", 64'(pkt_cnt[0 +: CW]), 64'h1);
    chk("post_rst_hdr", 64'(hdr[0 +: DW]), 64'hE);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ncu_mcu_link_mon.md
Name: ncu_mcu_link_mon

Overview:
- Synthesizable, parametrised protocol monitor for the NCU<->MCU serialized vld/data/stall links.
- One instance watches N_CH links in a single direction, either downstream (ncu_mcuN_*) or upstream (mcuN_ncu_*).
- Per channel it tracks packet framing and counts completed packets. It flags truncated packets and packets started against stall, and captures each packet's header beat.
- Replaces print-only monitoring with registered status usable by checkers and coverage.

Parameters:
- N_CH, 4, number of monitored links
- DATA_W, 4, link data width per beat
- PKT_BEATS, 32, beats per packet (minimum 2)
- CNT_W, 16, packet counter width per channel

Ports:
- iol2clk  in  1  monitor clock (all links synchronous to it)
- rst  in  1  asynchronous, active-high reset
- en  in  1  monitor enable (replaces plusarg disable)
- clr_cnt  in  1  synchronous clear of counters, sticky errors and first-error capture
- vld  in  N_CH  per-link packet valid
- data  in  N_CH*DATA_W  per-link beat data; channel i at [i*DATA_W +: DATA_W]
- stall  in  N_CH  per-link receiver stall
- pkt_done  out  N_CH  one-cycle pulse per completed packet
- pkt_cnt  out  N_CH*CNT_W  saturating completed-packet count per channel
- hdr  out  N_CH*DATA_W  beat 0 of the last completed packet per channel
- err_trunc  out  N_CH  sticky: vld dropped mid-packet
- err_stall_start  out  N_CH  sticky: packet started while stall high
- first_err_vld  out  1  a first error has been captured
- first_err_ch  out  clog2(N_CH) (min 1)  channel of first error
- first_err_code  out  2  01 = trunc, 10 = stall_start

Behaviour:
- Reset (async, rst=1): all outputs 0; all channel FSMs IDLE; beat counters 0.
- Per-channel FSM, states IDLE and XFER:
  - IDLE, vld=1 (en=1): this cycle is beat 0. Latch data into a pending-header register, set beat=1, go to XFER.
  - XFER, vld=1: beat increments.
  - XFER, vld=1 on beat PKT_BEATS-1: packet complete. pkt_done pulses next cycle, pkt_cnt increments, hdr <= pending header. FSM returns to IDLE.
  - Back-to-back: if vld stays high in the cycle after the last beat, that cycle is beat 0 of a new packet; no idle gap is required.
  - XFER, vld=0: truncation. Set err_trunc[i], go to IDLE, beat=0, no count, hdr unchanged.
- Stall rule:
  - Beat 0 sampled with stall[i]=1 sets err_stall_start[i].
  - The packet is still tracked and counted if complete.
  - Stall during XFER is legal and ignored.
- Latency: completion is visible one cycle after the last beat; pkt_done, pkt_cnt and hdr update in the same cycle. Errors are visible one cycle after the offending beat.
- pkt_cnt saturates at all-ones; pkt_done still pulses at saturation.
- en=0:
  - FSMs are forced to IDLE with beat=0.
  - A packet in progress is aborted silently: no error, no count.
  - Outputs hold their values; pkt_done=0.
- clr_cnt=1:
  - Next cycle, pkt_cnt, err_trunc, err_stall_start and first_err_* are all 0.
  - Clear wins over a same-cycle increment or error set.
  - FSM state, hdr and pkt_done are unaffected, so a completing packet still pulses pkt_done.
- First-error capture:
  - On the first cycle any error sets while first_err_vld=0, record the lowest-index erroring channel and its code.
  - Hold until clr_cnt or rst.
  - A single channel cannot raise both codes in one cycle.
- Mid-operation rst: immediate return to reset values; partial packets are discarded.

Test Plan:
- Ch0: 32 beats of vld=1, data=beat index mod 16, stall=0 -> pkt_done[0] pulses 1 cycle after beat 31; pkt_cnt[0]=1; hdr[0]=4'h0; no errors.
- Ch2: 64 consecutive vld cycles, header nibbles 4'hA then 4'h5 -> two pkt_done pulses 32 cycles apart; pkt_cnt[2]=2; hdr[2]=4'h5.
- Ch1: vld drops after beat 10 -> err_trunc[1]=1; first_err_vld=1, ch=1, code=01; pkt_cnt[1]=0. A following full packet then counts 1.
- Ch3 starts with stall=1 while, in the same cycle, ch1 truncates -> both sticky bits set; first_err_ch=1, code=01. Ch3 packet completes and counts.
- pkt_cnt at 16'hFFFE plus 2 packets -> saturates at 16'hFFFF. clr_cnt asserted coincident with a completion -> pkt_cnt=0, pkt_done still pulses.
- en deasserted at beat 5, reasserted with vld=1 -> no error; the re-entry cycle is beat 0 and a complete packet counts 1. rst asserted mid-packet -> all outputs 0 immediately.
